// File: rtl/ds18b20_sequencer.sv
// rtl/ds18b20_sequencer.sv - DS18B20 temperature-read command sequencer driving a 1-wire byte master
module ds18b20_sequencer #(
    parameter int PRES_TO     = 4000,
    parameter int XFER_TO     = 2000,
    parameter int CONV_TO     = 1500000,
    parameter int AUTO_PERIOD = 0
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] temp,
    output logic        temp_vld,
    output logic        err_nopres,
    output logic        err_crc,
    output logic        err_tmo,
    output logic        m_busrst,
    output logic        m_vld,
    output logic        m_we,
    output logic [3:0]  m_bits,
    output logic [7:0]  m_wdat,
    input  logic        m_rdy,
    input  logic        m_read,
    input  logic [7:0]  m_rdat
);
    typedef enum logic [3:0] {
        S_IDLE, S_RST1, S_SKIP1, S_CONV, S_POLL, S_RST2,
        S_SKIP2, S_RDSP, S_RDBYTE, S_CHECK, S_FIN
    } state_t;

    typedef enum logic [1:0] {PH_ISSUE, PH_WAIT, PH_CRC} phase_t;

    state_t      state;
    phase_t      phase;
    logic        skip;
    logic [31:0] wdog;
    logic [31:0] conv_cnt;
    logic [31:0] auto_cnt;
    logic [3:0]  idx;
    logic [2:0]  bit_cnt;
    logic [7:0]  crc;
    logic [7:0]  sh;
    logic [7:0]  hold0;
    logic [7:0]  hold1;
    logic [7:0]  rd_hold;
    logic [7:0]  rd_now;
    logic        auto_fire;
    logic        go;
    logic        iss_we;
    logic [3:0]  iss_bits;
    logic [7:0]  iss_wdat;

    // One Dallas CRC8 step (reflected poly 0x8C), fed LSB first.
    function automatic logic [7:0] crc8_bit(input logic [7:0] c, input logic d);
        crc8_bit = {1'b0, c[7:1]} ^ ((c[0] ^ d) ? 8'h8C : 8'h00);
    endfunction

    assign auto_fire = (AUTO_PERIOD != 0) && (auto_cnt == 32'd1);
    assign go        = start || auto_fire;
    assign rd_now    = m_read ? m_rdat : rd_hold;

    always_comb begin
        iss_we   = 1'b1;
        iss_bits = 4'd8;
        iss_wdat = 8'h00;
        case (state)
            S_SKIP1, S_SKIP2: iss_wdat = 8'hCC;
            S_CONV:           iss_wdat = 8'h44;
            S_RDSP:           iss_wdat = 8'hBE;
            S_POLL: begin
                iss_we   = 1'b0;
                iss_bits = 4'd1;
            end
            S_RDBYTE:         iss_we = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= S_IDLE;
            phase      <= PH_ISSUE;
            skip       <= 1'b0;
            wdog       <= 32'd0;
            conv_cnt   <= 32'd0;
            auto_cnt   <= 32'(AUTO_PERIOD);
            idx        <= 4'd0;
            bit_cnt    <= 3'd0;
            crc        <= 8'h00;
            sh         <= 8'h00;
            hold0      <= 8'h00;
            hold1      <= 8'h00;
            rd_hold    <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            temp       <= 16'h0000;
            temp_vld   <= 1'b0;
            err_nopres <= 1'b0;
            err_crc    <= 1'b0;
            err_tmo    <= 1'b0;
            m_busrst   <= 1'b0;
            m_vld      <= 1'b0;
            m_we       <= 1'b0;
            m_bits     <= 4'd0;
            m_wdat     <= 8'h00;
        end else begin
            m_busrst <= 1'b0;
            m_vld    <= 1'b0;
            done     <= 1'b0;

            if (auto_cnt != 32'd0)
                auto_cnt <= auto_cnt - 32'd1;
            if (state == S_POLL && conv_cnt != 32'd0)
                conv_cnt <= conv_cnt - 32'd1;
            if (phase == PH_WAIT && !skip && m_read)
                rd_hold <= m_rdat;

            case (state)
                S_IDLE: begin
                    // Accept also issues the first bus reset, so m_busrst follows start by one cycle.
                    if (go) begin
                        err_nopres <= 1'b0;
                        err_crc    <= 1'b0;
                        err_tmo    <= 1'b0;
                        busy       <= 1'b1;
                        m_busrst   <= 1'b1;
                        wdog       <= 32'(PRES_TO);
                        skip       <= 1'b1;
                        phase      <= PH_WAIT;
                        state      <= S_RST1;
                    end
                end
                S_CHECK: begin
                    if (crc == sh) begin
                        temp     <= {hold1, hold0};
                        temp_vld <= 1'b1;
                    end else begin
                        err_crc <= 1'b1;
                    end
                    state <= S_FIN;
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (AUTO_PERIOD != 0)
                        auto_cnt <= 32'(AUTO_PERIOD);
                end
                default: begin
                    if (state == S_POLL && conv_cnt == 32'd0) begin
                        err_tmo <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        case (phase)
                            PH_ISSUE: begin
                                skip    <= 1'b1;
                                phase   <= PH_WAIT;
                                rd_hold <= 8'h00;
                                if (state == S_RST2) begin
                                    m_busrst <= 1'b1;
                                    wdog     <= 32'(PRES_TO);
                                end else begin
                                    m_vld  <= 1'b1;
                                    m_we   <= iss_we;
                                    m_bits <= iss_bits;
                                    m_wdat <= iss_wdat;
                                    wdog   <= 32'(XFER_TO);
                                end
                            end
                            PH_WAIT: begin
                                if (skip) begin
                                    skip <= 1'b0;
                                end else if (m_rdy) begin
                                    phase <= PH_ISSUE;
                                    case (state)
                                        S_RST1:  state <= S_SKIP1;
                                        S_SKIP1: state <= S_CONV;
                                        S_CONV: begin
                                            state    <= S_POLL;
                                            conv_cnt <= 32'(CONV_TO);
                                        end
                                        S_POLL:  if (rd_now[0]) state <= S_RST2;
                                        S_RST2:  state <= S_SKIP2;
                                        S_SKIP2: state <= S_RDSP;
                                        S_RDSP: begin
                                            state <= S_RDBYTE;
                                            idx   <= 4'd0;
                                            crc   <= 8'h00;
                                        end
                                        S_RDBYTE: begin
                                            sh <= rd_now;
                                            if (idx == 4'd8) begin
                                                state <= S_CHECK;
                                            end else begin
                                                phase   <= PH_CRC;
                                                bit_cnt <= 3'd0;
                                                if (idx == 4'd0) hold0 <= rd_now;
                                                if (idx == 4'd1) hold1 <= rd_now;
                                            end
                                        end
                                        default: state <= S_FIN;
                                    endcase
                                end else if (wdog == 32'd0) begin
                                    if (state == S_RST1 || state == S_RST2)
                                        err_nopres <= 1'b1;
                                    else
                                        err_tmo <= 1'b1;
                                    state <= S_FIN;
                                end else begin
                                    wdog <= wdog - 32'd1;
                                end
                            end
                            PH_CRC: begin
                                crc     <= crc8_bit(crc, sh[0]);
                                sh      <= {1'b0, sh[7:1]};
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    phase <= PH_ISSUE;
                                    idx   <= idx + 4'd1;
                                end
                            end
                            default: phase <= PH_ISSUE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/ds18b20_sequencer.md
Name: ds18b20_sequencer

Overview:
- Command sequencer for a single DS18B20-class sensor on one 1-wire bus; it drives the existing 1-wire byte master (vld/we/bits/wdat in, rdy/read/rdat out) and owns the bus.
- One `start` runs a full temperature read: bus reset, Skip ROM, Convert T, conversion poll, bus reset, Skip ROM, Read Scratchpad, 9-byte read, CRC8 check.
- Publishes a 16-bit raw temperature plus sticky error flags to the register/CPU layer above.

Parameters:
- PRES_TO, 4000: clk cycles to wait for master rdy after bus reset (presence) before declaring no device.
- XFER_TO, 2000: clk cycles max for any byte/bit transaction before a timeout error.
- CONV_TO, 1500000: clk cycles max of conversion polling (750 ms at 2 MHz).
- AUTO_PERIOD, 0: if nonzero, self-start every AUTO_PERIOD cycles counted from `done`; 0 = manual start only.

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle request to run a sequence
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at sequence end (success or error)
- temp  out  16  raw scratchpad {byte1,byte0}; updated only on CRC-good completion
- temp_vld  out  1  set on first good update, cleared only by arst
- err_nopres  out  1  no presence after a bus reset
- err_crc  out  1  scratchpad CRC8 mismatch
- err_tmo  out  1  transaction or conversion timeout
- m_busrst  out  1  one-cycle bus-reset request to master
- m_vld  out  1  one-cycle transaction request
- m_we  out  1  1 = write, 0 = read
- m_bits  out  4  bit count, 8 for bytes, 1 for poll
- m_wdat  out  8  write byte, LSB first on wire
- m_rdy  in  1  master completion strobe
- m_read  in  1  master read-complete strobe
- m_rdat  in  8  read data, valid with m_read

Behaviour:
- Reset:
  - All outputs go to 0, temp = 0x0000, FSM to IDLE.
  - Asserting arst mid-sequence aborts immediately; no done pulse is generated.
- start:
  - Accepted only in IDLE. The same cycle it clears all err_* flags; busy goes high the next cycle.
  - start while busy is ignored.
- Auto mode: a period counter loads on done and on leaving reset; expiry acts as start. A coincident external start is merged into one run.
- Transaction primitive (ISSUE/WAIT):
  - Drive m_vld=1 for exactly 1 cycle with m_we/m_bits/m_wdat stable.
  - m_we/m_bits/m_wdat stay held until completion.
  - m_rdy is ignored in the issue cycle; completion is the first m_rdy=1 seen after it.
  - A watchdog loads XFER_TO at issue; reaching 0 sets err_tmo and jumps to FIN.
- Bus reset primitive: m_busrst=1 for 1 cycle, then wait for m_rdy within PRES_TO. Timeout sets err_nopres and jumps to FIN.
- State sequence:
  1. IDLE
  2. RST1
  3. SKIP1: write 0xCC
  4. CONV: write 0x44
  5. POLL: read 1 bit. Bit 0 repeats POLL; bit 1 goes to RST2. A CONV_TO counter runs across all POLL iterations; expiry sets err_tmo and jumps to FIN.
  6. RST2
  7. SKIP2: write 0xCC
  8. RDSP: write 0xBE
  9. RDBYTE: 9 reads of 8 bits, index 0..8. Bytes 0,1 are latched to holding registers.
  10. CHECK: 1 cycle
  11. FIN: done=1 and busy=0 in the same cycle, then IDLE.
- CRC:
  - Dallas CRC8, poly x^8+x^5+x^4+1, reflected 0x8C, init 0x00, bitwise LSB-first over bytes 0..7.
  - Byte 8 is compared in CHECK; CRC is updated serially, max 8 cycles per byte, before the next issue.
  - Mismatch sets err_crc and temp stays unchanged; match loads temp and sets temp_vld.
- Read data is captured on m_read; m_rdy without m_read during a read counts as completion with rdat ignored.
- Sticky errors hold until the next accepted start or arst. On any error, the first error set wins and later checks are skipped.

Test Plan:
- Device model answers presence, poll returns 0,0,1, scratchpad 50 05 4B 46 7F FF 0C 10 1C -> wire bytes CC,44,CC,BE in order; temp=0x0550, temp_vld=1, no errors, one done pulse.
- Same scratchpad but byte 8 = 0x1D -> err_crc=1, temp keeps prior value (0x0000 after reset), temp_vld=0, done pulses.
- No presence (m_rdy never after m_busrst) -> err_nopres=1 exactly PRES_TO+2 cycles after m_busrst, no m_vld issued, done pulses.
- Poll always returns 0 with CONV_TO=50 -> err_tmo=1, RST2 never entered; a second start clears err_tmo on its accept cycle.
- start pulsed during RDBYTE and arst asserted mid-CONV -> first start ignored (single done); after arst, all outputs 0, busy=0, no done.
- AUTO_PERIOD=100 -> second sequence m_busrst occurs 100 cycles after first done (±1), repeated unattended.
